// File: rtl/switch_led_pkg.sv
// rtl/switch_led_pkg.sv - mode encoding and chase constants for switch_led_controller
package switch_led_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_CHASE  = 2'd2
    } mode_t;

    localparam logic [3:0] CHASE_INIT = 4'b0001;
    localparam logic       DIR_UP     = 1'b0;
    localparam logic       DIR_DOWN   = 1'b1;

    // Bit 0 is LED1; up moves the lit LED toward LED4 and wraps back to LED1.
    function automatic logic [3:0] rotate_pattern(input logic [3:0] pattern, input logic dir);
        return (dir == DIR_UP) ? {pattern[2:0], pattern[3]} : {pattern[0], pattern[3:1]};
    endfunction

endpackage

// File: rtl/switch_led_controller_debounce.sv
// rtl/switch_led_controller_debounce.sv - two-flop synchronizer plus stability counter for one switch
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Raw,
    output logic o_Level,
    output logic o_Press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             raw_meta;
    logic             raw_sync;
    logic [CNT_W-1:0] count;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            raw_meta <= 1'b0;
            raw_sync <= 1'b0;
            count    <= '0;
            o_Level  <= 1'b0;
            o_Press  <= 1'b0;
        end else begin
            raw_meta <= i_Raw;
            raw_sync <= raw_meta;
            o_Press  <= 1'b0;
            if (raw_sync == o_Level) begin
                count <= '0;
            end else if (count == CNT_LAST) begin
                // Level follows only after DEBOUNCE_CYCLES consecutive disagreeing samples.
                count   <= '0;
                o_Level <= raw_sync;
                o_Press <= raw_sync;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/switch_led_controller.sv
// rtl/switch_led_controller.sv - debounced switch mode controller driving four LEDs, optional LED_PWM_EN dimming
module switch_led_controller
    import switch_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CHASE_CYCLES    = 6250000
`ifdef LED_PWM_EN
    ,
    parameter int PWM_BITS        = 4,
    parameter int PWM_DUTY        = 8
`endif
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch_1,
    input  logic i_Switch_2,
    input  logic i_Switch_3,
    input  logic i_Switch_4,
    output logic o_LED_1,
    output logic o_LED_2,
    output logic o_LED_3,
    output logic o_LED_4
);

    localparam int CHASE_W = (CHASE_CYCLES > 1) ? $clog2(CHASE_CYCLES) : 1;
    localparam logic [CHASE_W-1:0] CHASE_LAST = CHASE_W'(CHASE_CYCLES - 1);

    logic [3:0] raw;
    logic [3:0] level;
    logic [3:0] press;
    logic       unused_level;

    assign raw          = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
    assign unused_level = level[3];

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .i_Clk  (i_Clk),
            .i_Rst  (i_Rst),
            .i_Raw  (raw[i]),
            .o_Level(level[i]),
            .o_Press(press[i])
        );
    end

    mode_t              mode, mode_next;
    logic [2:0]         latch, latch_next;
    logic [3:0]         pattern, pattern_next;
    logic               dir, dir_next;
    logic               paused, paused_next;
    logic [CHASE_W-1:0] step_cnt, step_cnt_next;
    logic               step_tick;
    logic [3:0]         led_next;
    logic [3:0]         led_reg;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            mode <= MODE_MIRROR;
        end else begin
            mode <= mode_next;
        end
    end

    always_comb begin
        mode_next     = mode;
        latch_next    = latch;
        pattern_next  = pattern;
        dir_next      = dir;
        paused_next   = paused;
        step_cnt_next = step_cnt;
        led_next      = 4'b0000;
        step_tick     = !paused && (step_cnt == CHASE_LAST);
        // A mode advance swallows any switch 1-3 event arriving in the same cycle.
        case (mode)
            MODE_MIRROR: begin
                led_next = {1'b0, level[2:0]};
                if (press[3]) begin
                    mode_next  = MODE_TOGGLE;
                    latch_next = '0;
                end
            end
            MODE_TOGGLE: begin
                led_next = {1'b1, latch};
                if (press[3]) begin
                    mode_next     = MODE_CHASE;
                    pattern_next  = CHASE_INIT;
                    dir_next      = DIR_UP;
                    paused_next   = 1'b0;
                    step_cnt_next = '0;
                end else begin
                    latch_next = latch ^ press[2:0];
                end
            end
            MODE_CHASE: begin
                led_next = pattern;
                if (press[3]) begin
                    mode_next = MODE_MIRROR;
                end else begin
                    if (!paused) begin
                        step_cnt_next = step_tick ? '0 : step_cnt + CHASE_W'(1);
                    end
                    if (step_tick) begin
                        pattern_next = rotate_pattern(pattern, dir);
                    end
                    if (press[0]) begin
                        dir_next = ~dir;
                    end
                    if (press[1]) begin
                        paused_next = ~paused;
                    end
                end
            end
            default: begin
                mode_next = MODE_MIRROR;
            end
        endcase
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            latch    <= '0;
            pattern  <= '0;
            dir      <= DIR_UP;
            paused   <= 1'b0;
            step_cnt <= '0;
            led_reg  <= '0;
        end else begin
            latch    <= latch_next;
            pattern  <= pattern_next;
            dir      <= dir_next;
            paused   <= paused_next;
            step_cnt <= step_cnt_next;
            led_reg  <= led_next;
        end
    end

    logic [3:0] led_out;

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_count;
    logic                pwm_on;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            pwm_count <= '0;
        end else begin
            pwm_count <= pwm_count + PWM_BITS'(1);
        end
    end

    assign pwm_on  = (32'(pwm_count) < 32'(PWM_DUTY));
    assign led_out = led_reg & {4{pwm_on}};
`else
    assign led_out = led_reg;
`endif

    assign o_LED_1 = led_out[0];
    assign o_LED_2 = led_out[1];
    assign o_LED_3 = led_out[2];
    assign o_LED_4 = led_out[3];

endmodule
